fp_addsub_seq: RTL and testbench

//  Multi-cycle sequencer for the IEEE-754 FP add/sub datapath. Accepts one operand pair per

---
 rtl/fp_addsub_seq.sv | 202 ++++++++++++++++++++
 tb/tb_fp_addsub_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle sequencer for the FP add/sub datapath: screens special operands,
// steps the datapath through ALIGN/ADD/NORM/ROUND and holds the result under backpressure.
module fp_addsub_seq #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned EXP_BITS     = 8,
    parameter int unsigned MANT_BITS    = 23,
    parameter int unsigned NORM_TIMEOUT = 32,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sel,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_op,
    output logic             dp_align_en,
    output logic             dp_add_en,
    output logic             dp_norm_en,
    output logic             dp_round_en,
    input  logic             dp_norm_done,
    input  logic [WIDTH-1:0] dp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_invalid,
    output logic             flag_denorm,
    output logic             flag_timeout,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned WD_W = $clog2(NORM_TIMEOUT + 1);
    localparam logic [WIDTH-1:0] QNAN =
        {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MANT_BITS-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t            state, state_d;
    logic [WIDTH-1:0]  dp_a_d, dp_b_d, result_d;
    logic              dp_op_d, out_valid_d;
    logic              flag_invalid_d, flag_denorm_d, flag_timeout_d;
    logic [CNT_W-1:0]  op_count_d;
    logic [WD_W-1:0]   wdog, wdog_d;
    logic              eff_sign_b;

    function automatic logic exp_ones(input logic [WIDTH-1:0] x);
        return &x[WIDTH-2 -: EXP_BITS];
    endfunction

    function automatic logic exp_zero(input logic [WIDTH-1:0] x);
        return ~|x[WIDTH-2 -: EXP_BITS];
    endfunction

    function automatic logic mant_nz(input logic [WIDTH-1:0] x);
        return |x[MANT_BITS-1:0];
    endfunction

    function automatic logic is_nan(input logic [WIDTH-1:0] x);
        return exp_ones(x) & mant_nz(x);
    endfunction

    function automatic logic is_inf(input logic [WIDTH-1:0] x);
        return exp_ones(x) & ~mant_nz(x);
    endfunction

    function automatic logic is_denorm(input logic [WIDTH-1:0] x);
        return exp_zero(x) & mant_nz(x);
    endfunction

    // Denormals are flushed to a zero that keeps the operand's sign.
    function automatic logic [WIDTH-1:0] flush(input logic [WIDTH-1:0] x);
        return is_denorm(x) ? {x[WIDTH-1], {(WIDTH-1){1'b0}}} : x;
    endfunction

    assign eff_sign_b = dp_b[WIDTH-1] ^ ~dp_op;

    // Strobes and in_ready decode the registered state only.
    assign in_ready    = (state == S_IDLE);
    assign dp_align_en = (state == S_ALIGN);
    assign dp_add_en   = (state == S_ADD);
    assign dp_norm_en  = (state == S_NORM);
    assign dp_round_en = (state == S_ROUND);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            dp_a         <= '0;
            dp_b         <= '0;
            dp_op        <= 1'b0;
            result       <= '0;
            out_valid    <= 1'b0;
            flag_invalid <= 1'b0;
            flag_denorm  <= 1'b0;
            flag_timeout <= 1'b0;
            op_count     <= '0;
            wdog         <= '0;
        end else begin
            state        <= state_d;
            dp_a         <= dp_a_d;
            dp_b         <= dp_b_d;
            dp_op        <= dp_op_d;
            result       <= result_d;
            out_valid    <= out_valid_d;
            flag_invalid <= flag_invalid_d;
            flag_denorm  <= flag_denorm_d;
            flag_timeout <= flag_timeout_d;
            op_count     <= op_count_d;
            wdog         <= wdog_d;
        end
    end

    always_comb begin
        state_d        = state;
        dp_a_d         = dp_a;
        dp_b_d         = dp_b;
        dp_op_d        = dp_op;
        result_d       = result;
        out_valid_d    = out_valid;
        flag_invalid_d = flag_invalid;
        flag_denorm_d  = flag_denorm;
        flag_timeout_d = flag_timeout;
        op_count_d     = op_count;
        wdog_d         = wdog;

        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    dp_a_d         = flush(a);
                    dp_b_d         = flush(b);
                    dp_op_d        = op_sel;
                    flag_denorm_d  = is_denorm(a) | is_denorm(b);
                    flag_invalid_d = 1'b0;
                    flag_timeout_d = 1'b0;
                    state_d        = S_CHECK;
                end
            end
            S_CHECK: begin
                if (is_nan(dp_a) || is_nan(dp_b)) begin
                    result_d       = QNAN;
                    flag_invalid_d = 1'b1;
                    out_valid_d    = 1'b1;
                    state_d        = S_DONE;
                end else if (is_inf(dp_a) && is_inf(dp_b) && (dp_a[WIDTH-1] != eff_sign_b)) begin
                    result_d       = QNAN;
                    flag_invalid_d = 1'b1;
                    out_valid_d    = 1'b1;
                    state_d        = S_DONE;
                end else if (is_inf(dp_a)) begin
                    result_d    = dp_a;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (is_inf(dp_b)) begin
                    result_d    = {eff_sign_b, dp_b[WIDTH-2:0]};
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: state_d = S_ADD;
            S_ADD: begin
                wdog_d  = '0;
                state_d = S_NORM;
            end
            S_NORM: begin
                // A done in the last watchdog cycle still takes precedence.
                if (dp_norm_done) begin
                    state_d = S_ROUND;
                end else if (wdog == WD_W'(NORM_TIMEOUT - 1)) begin
                    result_d       = QNAN;
                    flag_timeout_d = 1'b1;
                    out_valid_d    = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    wdog_d = wdog + WD_W'(1);
                end
            end
            S_ROUND: begin
                result_d    = dp_result;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    op_count_d     = op_count + CNT_W'(1);
                    out_valid_d    = 1'b0;
                    flag_invalid_d = 1'b0;
                    flag_denorm_d  = 1'b0;
                    flag_timeout_d = 1'b0;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq; the bench plays the datapath and scores results via a queue.
module tb_fp_addsub_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned NORM_TIMEOUT = 32;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             op_sel = 1'b0;
    logic [WIDTH-1:0] dp_a, dp_b;
    logic             dp_op;
    logic             dp_align_en, dp_add_en, dp_norm_en, dp_round_en;
    logic             dp_norm_done = 1'b0;
    logic [WIDTH-1:0] dp_result = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] result;
    logic             flag_invalid, flag_denorm, flag_timeout;
    logic [CNT_W-1:0] op_count;

    typedef struct packed {
        logic [31:0] res;
        logic        fi;
        logic        fd;
        logic        ft;
    } exp_t;

    exp_t             sb_q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    logic [CNT_W-1:0] cnt_model = '0;

    fp_addsub_seq #(.NORM_TIMEOUT(NORM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sel(op_sel), .dp_a(dp_a), .dp_b(dp_b), .dp_op(dp_op),
        .dp_align_en(dp_align_en), .dp_add_en(dp_add_en), .dp_norm_en(dp_norm_en),
        .dp_round_en(dp_round_en), .dp_norm_done(dp_norm_done), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flag_invalid(flag_invalid), .flag_denorm(flag_denorm), .flag_timeout(flag_timeout),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit f_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 0);
    endfunction
    function automatic bit f_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 0);
    endfunction
    function automatic bit f_den(input logic [31:0] x);
        return (x[30:23] == 8'h00) && (x[22:0] != 0);
    endfunction
    function automatic logic [31:0] f_flush(input logic [31:0] x);
        return f_den(x) ? {x[31], 31'h0} : x;
    endfunction

    // done_at: NORM cycle (1-based) in which dp_norm_done is raised, 0 = never.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                          input logic [31:0] tres, input int done_at, input int hold);
        exp_t e;
        logic eb;
        bit   bypass;
        int   exp_lat, k, n_al, n_ad, n_no, n_ro, viol;
        eb     = tb[31] ^ ~top;
        bypass = 1'b1;
        e.fi = 1'b0; e.ft = 1'b0; e.fd = f_den(ta) | f_den(tb);
        if (f_nan(ta) || f_nan(tb))                       begin e.res = QNAN; e.fi = 1'b1; end
        else if (f_inf(ta) && f_inf(tb) && ta[31] != eb)  begin e.res = QNAN; e.fi = 1'b1; end
        else if (f_inf(ta))                                e.res = ta;
        else if (f_inf(tb))                                e.res = {eb, tb[30:0]};
        else begin
            bypass = 1'b0;
            if (done_at == 0) begin e.res = QNAN; e.ft = 1'b1; end
            else e.res = tres;
        end
        exp_lat = bypass ? 2 : (done_at == 0) ? 4 + NORM_TIMEOUT : 5 + done_at;
        sb_q.push_back(e);

        @(negedge clk);
        check_eq("in_ready_idle", 64'(in_ready), 64'd1);
        a = ta; b = tb; op_sel = top; dp_result = tres; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        k = 0; n_al = 0; n_ad = 0; n_no = 0; n_ro = 0; viol = 0;
        while (k < 200) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check_eq("dp_a_flush", 64'(dp_a), 64'(f_flush(ta)));
                check_eq("dp_b_flush", 64'(dp_b), 64'(f_flush(tb)));
                check_eq("dp_op", 64'(dp_op), 64'(top));
            end
            if (32'(dp_align_en) + 32'(dp_add_en) + 32'(dp_norm_en) + 32'(dp_round_en) > 1) viol++;
            if (out_valid && (dp_align_en | dp_add_en | dp_norm_en | dp_round_en)) viol++;
            n_al += 32'(dp_align_en); n_ad += 32'(dp_add_en); n_ro += 32'(dp_round_en);
            if (dp_norm_en) begin
                n_no++;
                dp_norm_done = (done_at != 0) && (n_no == done_at);
            end else begin
                dp_norm_done = 1'b0;
            end
            if (out_valid) break;
        end
        dp_norm_done = 1'b0;
        e = sb_q.pop_front();
        if (!out_valid) begin
            check_eq("out_valid_wait", 64'(out_valid), 64'd1);
            return;
        end
        check_eq("latency", 64'(k), 64'(exp_lat));
        check_eq("strobe_onehot", 64'(viol), 64'd0);
        check_eq("n_align", 64'(n_al), bypass ? 64'd0 : 64'd1);
        check_eq("n_add",   64'(n_ad), bypass ? 64'd0 : 64'd1);
        check_eq("n_norm",  64'(n_no), bypass ? 64'd0 : (done_at == 0) ? 64'(NORM_TIMEOUT) : 64'(done_at));
        check_eq("n_round", 64'(n_ro), (bypass || done_at == 0) ? 64'd0 : 64'd1);
        for (int h = 0; h < hold; h++) begin
            in_valid = (h < hold - 1);
            a = $urandom; b = $urandom;
            @(negedge clk);
            check_eq("hold_result", 64'(result), 64'(e.res));
            check_eq("hold_valid", 64'(out_valid), 64'd1);
            check_eq("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        check_eq("result", 64'(result), 64'(e.res));
        check_eq("flags", 64'({flag_invalid, flag_denorm, flag_timeout}), 64'({e.fi, e.fd, e.ft}));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        cnt_model = cnt_model + CNT_W'(1);
        check_eq("post_valid", 64'(out_valid), 64'd0);
        check_eq("post_flags", 64'({flag_invalid, flag_denorm, flag_timeout}), 64'd0);
        check_eq("op_count", 64'(op_count), 64'(cnt_model));
        check_eq("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        #1;
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_outs", 64'({out_valid, flag_invalid, flag_denorm, flag_timeout, dp_op}), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        check_eq("rst_count", 64'(op_count), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(32'h3F80_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 1, 0);
        run_op(32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h1234_5678, 1, 0);
        run_op(32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h1234_5678, 1, 0);
        run_op(32'h7F80_0001, 32'h3F80_0000, 1'b1, 32'h1234_5678, 1, 0);
        run_op(32'h3F80_0000, 32'hFF80_0000, 1'b0, 32'h1234_5678, 1, 0);
        run_op(32'h3F80_0000, 32'hFF80_0000, 1'b1, 32'h1234_5678, 1, 0);
        run_op(32'h0000_0001, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 2, 0);
        run_op(32'h8000_0000, 32'h807F_FFFF, 1'b0, 32'h0000_0000, 3, 0);
        run_op(32'h4000_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 0, 0);
        run_op(32'h4000_0000, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 32, 0);
        run_op(32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4080_0000, 4, 10);
        for (int i = 0; i < 4; i++)
            run_op($urandom & 32'h7EFF_FFFF, $urandom & 32'h7EFF_FFFF, 1'($urandom),
                   $urandom, int'($urandom_range(1, 8)), 0);

        // Abort an operation while it sits in NORM.
        @(negedge clk);
        a = 32'h3F80_0000; b = 32'h3F80_0000; op_sel = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("pre_rst_norm", 64'(dp_norm_en), 64'd1);
        rst_n = 1'b0;
        #1;
        cnt_model = '0;
        check_eq("mid_rst_strobes", 64'({dp_align_en, dp_add_en, dp_norm_en, dp_round_en}), 64'd0);
        check_eq("mid_rst_dp", 64'({dp_a, dp_b}), 64'd0);
        check_eq("mid_rst_count", 64'(op_count), 64'd0);
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rel_in_ready", 64'(in_ready), 64'd1);
        check_eq("rel_valid", 64'(out_valid), 64'd0);

        // Counter wrap: run bypass ops until the count wraps to 0.
        for (int i = 0; i < (1 << CNT_W); i++)
            run_op(32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'h0, 1, 0);
        check_eq("count_wrapped", 64'(op_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
